ptc_power_sequencer: RTL and testbench

Sequences the PTC low-voltage rails (3V3/2V5) and the six WIB 12 V enables from register-mapped requests, in the `clk_axi` domain. It sits between the register bank (`reg_rw_in`/`reg_ro_out` fields) and the `EN_3V3`/`EN_2V5`/`VP12_ENx` pins. It staggers turn-on to limit inrush, enforces LV-before-12V ordering, and forces every rail off on an alert or over-temperature condition. Faults latch until software clears them.

---
 rtl/ptc_pwr_pkg.sv | 21 ++
 rtl/ptc_sync2.sv | 26 ++
 rtl/ptc_power_sequencer.sv | 173 +++++++++++++++++
 tb/tb_ptc_power_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ptc_pwr_pkg.sv
// Shared types and constants for the PTC power sequencer: FSM encoding and
// the bit layout of the latched fault-source vector.
package ptc_pwr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LV_WAIT = 3'd1,
        ST_RUN     = 3'd2,
        ST_LV_DOWN = 3'd3,
        ST_FAULT   = 3'd4
    } pwr_state_e;

    localparam int N_CH_DEF = 6;

    // fault_src layout: {over_temp[2:0], lv_alert[1:0], vp12_alert[N_CH-1:0]}.
    // LV and over-temp fields sit at these offsets above the 12 V field.
    localparam int FSRC_VP12_LSB = 0;
    localparam int FSRC_LV_OFS   = 0;
    localparam int FSRC_OT_OFS   = 2;

endpackage

// File: rtl/ptc_sync2.sv
// Parameterized-width two-flop synchronizer with asynchronous active-high reset.
module ptc_sync2 #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ptc_power_sequencer.sv
// Sequences the PTC LV rails and the 12 V WIB channel enables with staggered
// turn-on, LV-before-12V ordering and latched fault shutdown.
module ptc_power_sequencer
    import ptc_pwr_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int DLY_W = 24
) (
    input  logic              clk_axi,
    input  logic              rst_axi,
    input  logic              lv_req,
    input  logic [N_CH-1:0]   cmd_en,
    input  logic [DLY_W-1:0]  step_delay,
    input  logic              fault_clr,
    input  logic [N_CH-1:0]   vp12_alert,
    input  logic [1:0]        lv_alert,
    input  logic [2:0]        over_temp,
    output logic              en_3v3,
    output logic              en_2v5,
    output logic [N_CH-1:0]   vp12_en,
    output logic              fault,
    output logic [N_CH+4:0]   fault_src,
    output logic              over_temp_led,
    output logic [2:0]        state
);

    localparam int SW     = N_CH + 5;
    localparam int LV_LSB = N_CH + FSRC_LV_OFS;
    localparam int OT_LSB = N_CH + FSRC_OT_OFS;

    logic [SW-1:0] raw_s;
    logic [N_CH-1:0] vp_s;
    logic [1:0] lv_s;
    logic [2:0] ot_s;

    ptc_sync2 #(.W(SW)) u_sync (
        .clk_i (clk_axi),
        .rst_i (rst_axi),
        .d_i   ({over_temp, lv_alert, vp12_alert}),
        .q_o   (raw_s)
    );

    assign vp_s = raw_s[FSRC_VP12_LSB +: N_CH];
    assign lv_s = raw_s[LV_LSB +: 2];
    assign ot_s = raw_s[OT_LSB +: 3];

    pwr_state_e state_q, state_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic lv_en_q, lv_en_d;
    logic [N_CH-1:0] vp12_en_q, vp12_en_d;
    logic fault_q, fault_d;
    logic [SW-1:0] fault_src_q, fault_src_d;

    logic [DLY_W-1:0] load_val;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] pick;
    logic [SW-1:0] trig;

    // A zero step delay still needs one countdown cycle between steps.
    assign load_val = (step_delay == '0) ? DLY_W'(1) : step_delay;
    assign pending  = cmd_en & ~vp12_en_q;
    assign pick     = pending & (~pending + N_CH'(1));
    assign trig     = {ot_s, lv_s & {2{lv_en_q}}, vp_s & vp12_en_q};

    always_ff @(posedge clk_axi or posedge rst_axi) begin
        if (rst_axi) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lv_en_q     <= 1'b0;
            vp12_en_q   <= '0;
            fault_q     <= 1'b0;
            fault_src_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lv_en_q     <= lv_en_d;
            vp12_en_q   <= vp12_en_d;
            fault_q     <= fault_d;
            fault_src_q <= fault_src_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lv_en_d     = lv_en_q;
        vp12_en_d   = vp12_en_q;
        fault_d     = fault_q;
        fault_src_d = fault_src_q;

        // Fault detection outranks every other transition in the same cycle.
        if (state_q != ST_FAULT && trig != '0) begin
            state_d     = ST_FAULT;
            cnt_d       = '0;
            lv_en_d     = 1'b0;
            vp12_en_d   = '0;
            fault_d     = 1'b1;
            fault_src_d = fault_src_q | trig;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    lv_en_d   = 1'b0;
                    vp12_en_d = '0;
                    if (lv_req && (ot_s == '0) && (lv_s == '0)) begin
                        lv_en_d = 1'b1;
                        cnt_d   = load_val;
                        state_d = ST_LV_WAIT;
                    end
                end
                ST_LV_WAIT: begin
                    if (!lv_req) begin
                        cnt_d   = load_val;
                        state_d = ST_LV_DOWN;
                    end else if (cnt_q <= DLY_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - DLY_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lv_req) begin
                        vp12_en_d = '0;
                        cnt_d     = load_val;
                        state_d   = ST_LV_DOWN;
                    end else begin
                        // Deselected channels drop at once; at most one new channel per step.
                        vp12_en_d = vp12_en_q & cmd_en;
                        if (cnt_q == '0 && pending != '0) begin
                            vp12_en_d = (vp12_en_q & cmd_en) | pick;
                            cnt_d     = load_val;
                        end else if (cnt_q != '0) begin
                            cnt_d = cnt_q - DLY_W'(1);
                        end
                    end
                end
                ST_LV_DOWN: begin
                    vp12_en_d = '0;
                    if (cnt_q == '0) begin
                        lv_en_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - DLY_W'(1);
                    end
                end
                ST_FAULT: begin
                    lv_en_d     = 1'b0;
                    vp12_en_d   = '0;
                    fault_src_d = fault_src_q | raw_s;
                    if (fault_clr && raw_s == '0 && !lv_req) begin
                        fault_d     = 1'b0;
                        fault_src_d = '0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    lv_en_d   = 1'b0;
                    vp12_en_d = '0;
                    state_d   = ST_IDLE;
                end
            endcase
        end
    end

    assign en_3v3        = lv_en_q;
    assign en_2v5        = lv_en_q;
    assign vp12_en       = vp12_en_q;
    assign fault         = fault_q;
    assign fault_src     = fault_src_q;
    assign over_temp_led = |fault_src_q[OT_LSB +: 3];
    assign state         = state_q;

endmodule

// File: tb/tb_ptc_power_sequencer.sv
// Directed self-checking bench for ptc_power_sequencer: sequencing, shutdown,
// fault latching/clearing, reset and zero step delay.
module tb_ptc_power_sequencer;

    localparam int N_CH  = 6;
    localparam int DLY_W = 24;

    logic              clk_axi;
    logic              rst_axi;
    logic              lv_req;
    logic [N_CH-1:0]   cmd_en;
    logic [DLY_W-1:0]  step_delay;
    logic              fault_clr;
    logic [N_CH-1:0]   vp12_alert;
    logic [1:0]        lv_alert;
    logic [2:0]        over_temp;
    logic              en_3v3;
    logic              en_2v5;
    logic [N_CH-1:0]   vp12_en;
    logic              fault;
    logic [N_CH+4:0]   fault_src;
    logic              over_temp_led;
    logic [2:0]        state;

    int n_checks = 0;
    int n_pass   = 0;
    int rise_cyc [N_CH];
    logic multi_rise;

    ptc_power_sequencer #(.N_CH(N_CH), .DLY_W(DLY_W)) dut (
        .clk_axi       (clk_axi),
        .rst_axi       (rst_axi),
        .lv_req        (lv_req),
        .cmd_en        (cmd_en),
        .step_delay    (step_delay),
        .fault_clr     (fault_clr),
        .vp12_alert    (vp12_alert),
        .lv_alert      (lv_alert),
        .over_temp     (over_temp),
        .en_3v3        (en_3v3),
        .en_2v5        (en_2v5),
        .vp12_en       (vp12_en),
        .fault         (fault),
        .fault_src     (fault_src),
        .over_temp_led (over_temp_led),
        .state         (state)
    );

    initial clk_axi = 1'b0;
    always #5 clk_axi = ~clk_axi;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_axi);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_clr();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
    endtask

    task automatic wait_vp(input string tag, input logic [N_CH-1:0] exp, input int max_cyc);
        for (int i = 0; i < max_cyc && vp12_en !== exp; i++) tick();
        check(tag, vp12_en, exp);
    endtask

    // Cycle 0 is the cycle lv_req was driven; cycle c is c clock edges later.
    task automatic run_and_record(input int ncyc);
        logic [N_CH-1:0] prev;
        for (int i = 0; i < N_CH; i++) rise_cyc[i] = 0;
        multi_rise = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            prev = vp12_en;
            tick();
            if ($countones(vp12_en & ~prev) > 1) multi_rise = 1'b1;
            for (int i = 0; i < N_CH; i++)
                if (vp12_en[i] && !prev[i]) rise_cyc[i] = c;
            if (c == 1) begin
                check("lv3v3_cycle1", en_3v3, 1);
                check("lv2v5_cycle1", en_2v5, 1);
                check("state_lvwait", state, 1);
            end
        end
    endtask

    initial begin
        rst_axi    = 1'b1;
        lv_req     = 1'b0;
        cmd_en     = '0;
        step_delay = 24'd4;
        fault_clr  = 1'b0;
        vp12_alert = '0;
        lv_alert   = '0;
        over_temp  = '0;
        ticks(3);

        check("rst_state", state, 0);
        check("rst_en3v3", en_3v3, 0);
        check("rst_vp12", vp12_en, 0);
        check("rst_fault", fault, 0);
        check("rst_fsrc", fault_src, 0);
        rst_axi = 1'b0;
        ticks(2);

        // Sequence up, step_delay=4
        cmd_en = 6'b101001;
        lv_req = 1'b1;
        run_and_record(18);
        check("ch0_rise", rise_cyc[0], 6);
        check("ch3_rise", rise_cyc[3], 11);
        check("ch5_rise", rise_cyc[5], 16);
        check("one_per_cycle", multi_rise, 0);
        check("run_state", state, 2);
        check("run_mask", vp12_en, 6'b101001);

        // Deselected channel drops at once, then returns after the countdown
        cmd_en = 6'b100001;
        tick();
        check("cmd_clear", vp12_en, 6'b100001);
        cmd_en = 6'b101001;
        tick();
        check("ch3_wait", vp12_en, 6'b100001);
        tick();
        check("ch3_back", vp12_en, 6'b101001);

        // Shutdown
        lv_req = 1'b0;
        tick();
        check("down_vp12", vp12_en, 0);
        check("down_state", state, 3);
        check("down_lv_held", en_3v3, 1);
        ticks(4);
        check("down_lv_still", en_2v5, 1);
        tick();
        check("down_lv3v3_off", en_3v3, 0);
        check("down_lv2v5_off", en_2v5, 0);
        check("down_idle", state, 0);

        // Masked alert, then channel fault
        step_delay = 24'd2;
        cmd_en     = 6'b001001;
        lv_req     = 1'b1;
        wait_vp("fault_setup", 6'b001001, 40);
        vp12_alert = 6'b000100;
        ticks(5);
        check("masked_nofault", fault, 0);
        check("masked_run", state, 2);
        vp12_alert = '0;
        ticks(3);
        vp12_alert = 6'b001000;
        tick();
        vp12_alert = '0;
        tick();
        check("chflt_not_yet", vp12_en, 6'b001001);
        tick();
        check("chflt_vp12", vp12_en, 0);
        check("chflt_lv", en_3v3, 0);
        check("chflt_state", state, 4);
        check("chflt_fault", fault, 1);
        ticks(3);
        check("chflt_src", fault_src, 11'h008);
        lv_req = 1'b0;
        pulse_clr();
        check("chflt_clr_state", state, 0);
        check("chflt_clr_fault", fault, 0);
        check("chflt_clr_src", fault_src, 0);

        // Over-temp during LV_WAIT
        step_delay = 24'd20;
        cmd_en     = '0;
        lv_req     = 1'b1;
        tick();
        check("ot_lvwait", state, 1);
        over_temp = 3'b010;
        ticks(3);
        check("ot_state", state, 4);
        check("ot_led", over_temp_led, 1);
        check("ot_lv_off", en_3v3, 0);
        check("ot_src", fault_src, 11'h200);
        pulse_clr();
        check("ot_clr_blocked_both", state, 4);
        lv_req = 1'b0;
        pulse_clr();
        check("ot_clr_blocked_ot", state, 4);
        over_temp = '0;
        lv_req    = 1'b1;
        ticks(3);
        pulse_clr();
        check("ot_clr_blocked_req", state, 4);
        lv_req = 1'b0;
        pulse_clr();
        check("ot_clr_state", state, 0);
        check("ot_clr_fault", fault, 0);
        check("ot_clr_led", over_temp_led, 0);

        // step_delay=0 behaves as 1
        step_delay = 24'd0;
        cmd_en     = 6'b000111;
        lv_req     = 1'b1;
        run_and_record(10);
        check("sd0_ch0", rise_cyc[0], 3);
        check("sd0_ch1", rise_cyc[1], 5);
        check("sd0_ch2", rise_cyc[2], 7);
        check("sd0_one_per_cycle", multi_rise, 0);

        // Asynchronous reset mid-RUN
        #2;
        rst_axi = 1'b1;
        #1;
        check("arst_vp12", vp12_en, 0);
        check("arst_lv", en_3v3, 0);
        check("arst_state", state, 0);
        lv_req = 1'b0;
        tick();
        rst_axi = 1'b0;
        tick();
        check("arst_after_state", state, 0);
        check("arst_after_fault", fault, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
